// File: rtl/button_events_pkg.sv
// ---------------------------------------------------------------------------
// button_events_pkg
// Shared definitions for the button event classifier:
//   - FSM state encoding (5 states, 3-bit)
//   - default LONG_CYCLES / GAP_CYCLES / CNT_WIDTH values
//   - event-index constants for a future bundled event vector
//   - helper used when checking the parameters at elaboration
// ---------------------------------------------------------------------------
package button_events_pkg;

  localparam int unsigned STATE_W = 3;

  // Gesture FSM states
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_PRESSED   = 3'd1,
    ST_WAIT_GAP  = 3'd2,
    ST_SECOND    = 3'd3,
    ST_LONG_HELD = 3'd4
  } state_e;

  // Default timing parameters
  localparam int unsigned DEF_LONG_CYCLES = 50;
  localparam int unsigned DEF_GAP_CYCLES  = 20;
  localparam int unsigned DEF_CNT_WIDTH   = 16;

  // Bit positions if the events are ever packed into one vector
  localparam int unsigned EV_PRESS   = 0;
  localparam int unsigned EV_RELEASE = 1;
  localparam int unsigned EV_CLICK   = 2;
  localparam int unsigned EV_DCLICK  = 3;
  localparam int unsigned EV_LONG    = 4;
  localparam int unsigned EV_COUNT   = 5;

  // True when val is representable in an unsigned field of width w
  function automatic bit fits_width(input int unsigned val, input int unsigned w);
    if (w >= 32) begin
      return 1'b1;
    end
    return (64'(val) < (64'd1 << w));
  endfunction

endpackage

// File: rtl/button_edge_detect.sv
// ---------------------------------------------------------------------------
// button_edge_detect
// Registers the debounced button level and flags its edges.
// Ports:
//   clock        - system clock, rising edge
//   reset        - asynchronous active-low reset
//   i_button_in  - debounced button level
//   o_held       - registered copy of i_button_in (0 in reset)
//   o_rise_c     - combinational: current sample is 1, previous was 0
//   o_fall_c     - combinational: current sample is 0, previous was 1
// ---------------------------------------------------------------------------
module button_edge_detect
  import button_events_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_button_in,
  output logic o_held,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_held;

  // Previous-sample register; reset to 0 so a button already down at
  // reset release is reported as a rise on the first sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_held <= 1'b0;
    end else begin
      r_held <= i_button_in;
    end
  end

  assign o_held   = r_held;
  assign o_rise_c = i_button_in & ~r_held;
  assign o_fall_c = ~i_button_in & r_held;

endmodule

// File: rtl/button_events.sv
// ---------------------------------------------------------------------------
// button_events
// Turns a debounced button level into one-cycle event pulses:
// press, release, click, double-click and long-press, plus a registered
// held level. Every output is registered, so an event appears one cycle
// after the clock edge at which its cause is sampled.
//
// Optional feature macro: BUTTON_EVENTS_DCLICK_EN
//   defined   - double-click detection; a click is only issued after the
//               release gap expires without a second press
//   undefined - no WAIT_GAP/SECOND states, o_double_click tied 0, click is
//               issued together with release; GAP_CYCLES is only range-checked
//
// Ports:
//   clock           - system clock, rising edge
//   reset           - asynchronous active-low reset
//   i_button_in     - debounced button level, synchronous to clock
//   o_held          - registered copy of i_button_in
//   o_press         - pulse on every 0->1 of the button
//   o_release       - pulse on every 1->0 of the button
//   o_click         - pulse for a completed single short press
//   o_double_click  - pulse for two short presses within GAP_CYCLES
//   o_long_press    - pulse when a hold reaches LONG_CYCLES
// ---------------------------------------------------------------------------
module button_events
  import button_events_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic i_button_in,
  output logic o_held,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_double_click,
  output logic o_long_press
);

  // Reject unusable timing parameters at elaboration
  if (LONG_CYCLES < 2 || GAP_CYCLES < 2 || !fits_width(LONG_CYCLES, CNT_WIDTH)) begin : g_param_err
    $error("button_events: LONG_CYCLES/GAP_CYCLES must be >= 2 and LONG_CYCLES must fit CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENTS_DCLICK_EN
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
`endif

  logic w_held;
  logic w_rise;
  logic w_fall;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic r_press;
  logic r_release;
  logic r_click;
  logic r_long;
  logic w_click_nxt;
  logic w_long_nxt;
`ifdef BUTTON_EVENTS_DCLICK_EN
  logic r_dclick;
  logic w_dclick_nxt;
`endif

  button_edge_detect u_edge (
    .clock       (clock),
    .reset       (reset),
    .i_button_in (i_button_in),
    .o_held      (w_held),
    .o_rise_c    (w_rise),
    .o_fall_c    (w_fall)
  );

  // Gesture classifier: next state and gesture pulses.
  // A fall is always checked before the long-press threshold so that a
  // release on the threshold cycle still counts as a short press.
  always_comb begin
    w_state_nxt  = r_state;
    w_click_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
`ifdef BUTTON_EVENTS_DCLICK_EN
    w_dclick_nxt = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (w_fall) begin
`ifdef BUTTON_EVENTS_DCLICK_EN
          w_state_nxt = ST_WAIT_GAP;
`else
          w_click_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
`endif
        end else if (r_cnt == LONG_LAST) begin
          w_long_nxt  = 1'b1;
          w_state_nxt = ST_LONG_HELD;
        end
      end
`ifdef BUTTON_EVENTS_DCLICK_EN
      ST_WAIT_GAP: begin
        // A second press on the timeout cycle still makes a double-click
        if (w_rise) begin
          w_state_nxt = ST_SECOND;
        end else if (r_cnt == GAP_LAST) begin
          w_click_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SECOND: begin
        if (w_fall) begin
          w_dclick_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (r_cnt == LONG_LAST) begin
          w_long_nxt  = 1'b1;
          w_state_nxt = ST_LONG_HELD;
        end
      end
`endif
      ST_LONG_HELD: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, shared saturating counter and registered event outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_long    <= 1'b0;
`ifdef BUTTON_EVENTS_DCLICK_EN
      r_dclick  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      r_press   <= w_rise;
      r_release <= w_fall;
      r_click   <= w_click_nxt;
      r_long    <= w_long_nxt;
`ifdef BUTTON_EVENTS_DCLICK_EN
      r_dclick  <= w_dclick_nxt;
`endif
    end
  end

  assign o_held         = w_held;
  assign o_press        = r_press;
  assign o_release      = r_release;
  assign o_click        = r_click;
  assign o_long_press   = r_long;
`ifdef BUTTON_EVENTS_DCLICK_EN
  assign o_double_click = r_dclick;
`else
  assign o_double_click = 1'b0;
`endif

endmodule

// File: tb/tb_button_events.sv
// ---------------------------------------------------------------------------
// tb_button_events
// Self-checking bench for button_events (LONG_CYCLES=8, GAP_CYCLES=4).
// Each driven sample pushes the expected output vector
// {held, press, release, click, double_click, long_press} one cycle later;
// the vector is popped and compared on the following falling edge.
// Expectations follow BUTTON_EVENTS_DCLICK_EN the same way the DUT does.
// ---------------------------------------------------------------------------
module tb_button_events;

  localparam int LONG = 8;
  localparam int GAP  = 4;

  localparam int G_IDLE   = 0;
  localparam int G_FIRST  = 1;
  localparam int G_GAP    = 2;
  localparam int G_SECOND = 3;
  localparam int G_LONG   = 4;

  logic clock;
  logic reset;
  logic i_button_in;
  logic o_held, o_press, o_release, o_click, o_double_click, o_long_press;
  logic [5:0] obs;

  int n_cmp;
  int n_err;
  int cyc;
  string phase;

  logic [5:0] exp_q[$];

  // Reference gesture tracker: counts samples of each run length
  logic m_prev;
  int   m_g;
  int   m_hi;
  int   m_lo;

  button_events #(
    .LONG_CYCLES (LONG),
    .GAP_CYCLES  (GAP),
    .CNT_WIDTH   (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .i_button_in    (i_button_in),
    .o_held         (o_held),
    .o_press        (o_press),
    .o_release      (o_release),
    .o_click        (o_click),
    .o_double_click (o_double_click),
    .o_long_press   (o_long_press)
  );

  assign obs = {o_held, o_press, o_release, o_click, o_double_click, o_long_press};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (held,press,rel,click,dclick,long)", tag, act, want);
    end
  endtask

  // Expected outputs produced by sampling b at the next rising edge
  task automatic model_push(input logic b);
    logic [5:0] e;
    e    = '0;
    e[5] = b;
    e[4] = b & ~m_prev;
    e[3] = ~b & m_prev;
    case (m_g)
      G_IDLE: begin
        if (b) begin
          m_g  = G_FIRST;
          m_hi = 1;
        end
      end
      G_FIRST: begin
        if (b) begin
          m_hi++;
          if (m_hi == LONG + 1) begin
            e[0] = 1'b1;
            m_g  = G_LONG;
          end
        end else begin
`ifdef BUTTON_EVENTS_DCLICK_EN
          m_g  = G_GAP;
          m_lo = 1;
`else
          e[2] = 1'b1;
          m_g  = G_IDLE;
`endif
        end
      end
      G_GAP: begin
        if (b) begin
          m_g  = G_SECOND;
          m_hi = 1;
        end else begin
          m_lo++;
          if (m_lo == GAP + 1) begin
            e[2] = 1'b1;
            m_g  = G_IDLE;
          end
        end
      end
      G_SECOND: begin
        if (b) begin
          m_hi++;
          if (m_hi == LONG + 1) begin
            e[0] = 1'b1;
            m_g  = G_LONG;
          end
        end else begin
          e[1] = 1'b1;
          m_g  = G_IDLE;
        end
      end
      default: begin
        if (!b) m_g = G_IDLE;
      end
    endcase
    m_prev = b;
    exp_q.push_back(e);
  endtask

  // Drive one sample, then compare the registered result a cycle later
  task automatic step(input logic b);
    logic [5:0] want;
    i_button_in = b;
    model_push(b);
    @(negedge clock);
    cyc++;
    want = exp_q.pop_front();
    check($sformatf("%s@%0d", phase, cyc), 32'(obs), 32'(want));
  endtask

  task automatic gesture(input int hi, input int lo);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  task automatic model_reset();
    m_prev = 1'b0;
    m_g    = G_IDLE;
    m_hi   = 0;
    m_lo   = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    model_reset();

    // Reset low for 20 ns with the button already down
    phase       = "reset";
    reset       = 1'b0;
    i_button_in = 1'b1;
    repeat (2) @(negedge clock);
    check("reset_outputs", 32'(obs), 32'd0);
    reset = 1'b1;

    // Button down at reset release: press on first sample, then single click
    phase = "single";
    gesture(3, 8);

    phase = "double";
    gesture(2, 2);
    gesture(2, 8);

    phase = "long";
    gesture(12, 8);

    // Second press lands exactly on the last gap cycle
    phase = "gap_edge";
    gesture(2, GAP);
    gesture(2, 8);

    // Release on the long threshold stays short; one sample later goes long
    phase = "long_edge";
    gesture(LONG, 8);
    gesture(LONG + 1, 8);

    // Gap one cycle too long: two separate clicks
    phase = "gap_over";
    gesture(2, GAP + 1);
    gesture(2, 8);

    // Second press held into long-press
    phase = "second_long";
    gesture(2, 2);
    gesture(10, 8);

    // Reset while waiting in the gap: pending click is dropped
    phase = "mid_reset";
    gesture(2, 2);
    reset       = 1'b0;
    i_button_in = 1'b0;
    model_reset();
    #1;
    check("mid_reset_outputs", 32'(obs), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (8) step(1'b0);

    // Random gestures
    phase = "random";
    for (int i = 0; i < 20; i++) begin
      gesture(int'($urandom_range(1, 11)), int'($urandom_range(1, 7)));
    end
    repeat (8) step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
